// File: rtl/ring_freq_meter_if.sv
// ring_freq_meter_if: control/readout bus (start, abort, gate_len, ch_sel in; busy, done, value_out, ovf_out out)
interface ring_freq_meter_if #(
  parameter int GATE_W = 16,
  parameter int CNT_W = 16,
  parameter int CH_W = 2
);
  logic start;
  logic abort;
  logic [GATE_W-1:0] gate_len;
  logic [CH_W-1:0] ch_sel;
  logic busy;
  logic done;
  logic [CNT_W-1:0] value_out;
  logic ovf_out;
  modport master (output start, abort, gate_len, ch_sel, input busy, done, value_out, ovf_out);
  modport slave (input start, abort, gate_len, ch_sel, output busy, done, value_out, ovf_out);
endinterface

// File: rtl/ring_freq_meter.sv
// ring_freq_meter: gated multi-channel ring-oscillator edge counter (clk, rst, ring_in[N_CH] async, bus: start/abort/gate_len in, busy/done/value_out/ovf_out out)
module ring_freq_meter #(
  parameter int N_CH = 4,
  parameter int CNT_W = 16,
  parameter int GATE_W = 16,
  parameter int CH_W = 2
) (
  input logic clk,
  input logic rst,
  input logic [N_CH-1:0] ring_in,
  ring_freq_meter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;
  state_t state;
  logic [N_CH-1:0] s1, s2, s3, rise, sat, lovf, lovf_nxt, rovf;
  logic [GATE_W-1:0] glen, timer;
  logic [CNT_W-1:0] live [N_CH];
  logic [CNT_W-1:0] live_nxt [N_CH];
  logic [CNT_W-1:0] res [N_CH];
  logic gate_en, sel_ok;
  assign rise = s2 & ~s3;
  assign gate_en = state == GATE;
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      sat[i] = &live[i];
      live_nxt[i] = (gate_en && rise[i] && !sat[i]) ? live[i] + CNT_W'(1) : live[i];
    end
  end
  assign lovf_nxt = lovf | (gate_en ? rise & sat : '0);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      glen <= '0;
      timer <= '0;
      lovf <= '0;
      rovf <= '0;
      for (int i = 0; i < N_CH; i++) begin
        live[i] <= '0;
        res[i] <= '0;
      end
    end else begin
      s1 <= ring_in;
      s2 <= s1;
      s3 <= s2;
      live <= live_nxt;
      lovf <= lovf_nxt;
      case (state)
        IDLE: if (bus.start && bus.gate_len != '0) begin
          state <= ARM;
          glen <= bus.gate_len;
          timer <= GATE_W'(2);
          lovf <= '0;
          for (int i = 0; i < N_CH; i++) live[i] <= '0;
        end
        ARM: begin
          state <= bus.abort ? IDLE : timer == '0 ? GATE : ARM;
          timer <= timer == '0 ? glen - GATE_W'(1) : timer - GATE_W'(1);
        end
        GATE: begin
          state <= bus.abort ? IDLE : timer == '0 ? DONE : GATE;
          timer <= timer - GATE_W'(1);
          if (!bus.abort && timer == '0) begin
            res <= live_nxt;
            rovf <= lovf_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign sel_ok = 32'(bus.ch_sel) < N_CH;
  assign bus.value_out = sel_ok ? res[bus.ch_sel] : '0;
  assign bus.ovf_out = sel_ok ? rovf[bus.ch_sel] : 1'b0;
endmodule

// File: tb/tb_ring_freq_meter.sv
// tb_ring_freq_meter: scoreboard bench for ring_freq_meter (4ch/16b and 3ch/8b instances)
module tb_ring_freq_meter;
  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0][31:0] lo;
    logic [3:0][31:0] hi;
    logic [3:0] ovf;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  int cyc = 0;
  int ncmp = 0;
  int nfail = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int per[7] = '{default: 0};
  int ph[7] = '{default: 0};
  logic [6:0] rv = '0;
  logic m0 = 0;
  logic [1:0] s0m = '0, s0s = '0;
  ring_freq_meter_if b0 ();
  ring_freq_meter_if #(.CNT_W(8)) b1 ();
  assign b0.ch_sel = m0 ? s0m : s0s;
  ring_freq_meter u0 (.clk(clk), .rst(rst), .ring_in(rv[3:0]), .bus(b0));
  ring_freq_meter #(.N_CH(3), .CNT_W(8)) u1 (.clk(clk), .rst(rst), .ring_in(rv[6:4]), .bus(b1));
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    for (int i = 0; i < 7; i++) begin
      ph[i] <= per[i] == 0 ? 0 : (ph[i] + 1) % per[i];
      rv[i] <= per[i] != 0 && ph[i] < per[i] / 2;
    end
  task automatic chk(input string nm, input int act, input int lo, input int hi);
    ncmp++;
    if (act < lo || act > hi) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask
  function automatic exp_t mk(input int c, input int g, input int p0, input int p1, input int p2, input int p3, input int mx);
    exp_t e;
    int ps[4];
    int lo, hi;
    ps = '{p0, p1, p2, p3};
    e = '0;
    e.cyc = 32'(c + 4 + g);
    for (int i = 0; i < 4; i++) begin
      lo = ps[i] == 0 ? 0 : g / ps[i] - 1;
      hi = ps[i] == 0 ? 0 : (g + ps[i] - 1) / ps[i] + 1;
      if (lo < 0) lo = 0;
      if (lo > mx) begin
        lo = mx;
        e.ovf[i] = 1'b1;
      end
      if (hi > mx) hi = mx;
      e.lo[i] = 32'(lo);
      e.hi[i] = 32'(hi);
    end
    return e;
  endfunction
  initial forever begin
    @(negedge clk);
    if (b0.done) begin
      if (q0.size() == 0) chk("done0_unexpected", 1, 0, 0);
      else begin
        e0 = q0.pop_front();
        chk("done0_cycle", cyc, int'(e0.cyc), int'(e0.cyc));
        m0 = 1;
        for (int i = 0; i < 4; i++) begin
          s0m = 2'(i);
          #1;
          chk($sformatf("val0_ch%0d", i), int'(b0.value_out), int'(e0.lo[i]), int'(e0.hi[i]));
          chk($sformatf("ovf0_ch%0d", i), int'(b0.ovf_out), int'(e0.ovf[i]), int'(e0.ovf[i]));
        end
        m0 = 0;
        @(negedge clk);
        chk("busy0_after_done", int'(b0.busy), 0, 0);
      end
    end
  end
  initial begin
    b1.ch_sel = '0;
    forever begin
      @(negedge clk);
      if (b1.done) begin
        if (q1.size() == 0) chk("done1_unexpected", 1, 0, 0);
        else begin
          e1 = q1.pop_front();
          chk("done1_cycle", cyc, int'(e1.cyc), int'(e1.cyc));
          for (int i = 0; i < 4; i++) begin
            b1.ch_sel = 2'(i);
            #1;
            chk($sformatf("val1_ch%0d", i), int'(b1.value_out), int'(e1.lo[i]), int'(e1.hi[i]));
            chk($sformatf("ovf1_ch%0d", i), int'(b1.ovf_out), int'(e1.ovf[i]), int'(e1.ovf[i]));
          end
          @(negedge clk);
          chk("busy1_after_done", int'(b1.busy), 0, 0);
        end
      end
    end
  end
  task automatic go0(input int g, output int c);
    @(negedge clk);
    b0.gate_len = 16'(g);
    b0.start = 1;
    c = cyc;
    @(negedge clk);
    b0.start = 0;
  endtask
  task automatic go1(input int g, output int c);
    @(negedge clk);
    b1.gate_len = 16'(g);
    b1.start = 1;
    c = cyc;
    @(negedge clk);
    b1.start = 0;
  endtask
  task automatic idle0();
    int n = 0;
    while ((q0.size() != 0 || b0.busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("wait0_bound", n, 0, 2999);
    repeat (2) @(negedge clk);
  endtask
  task automatic idle1();
    int n = 0;
    while ((q1.size() != 0 || b1.busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("wait1_bound", n, 0, 2999);
    repeat (2) @(negedge clk);
  endtask
  task automatic rd0(input string nm, input int lo, input int hi, input int ch_hi);
    for (int i = 0; i < 4; i++) begin
      s0s = 2'(i);
      #1;
      chk($sformatf("%s_val_ch%0d", nm, i), int'(b0.value_out), i <= ch_hi ? lo : 0, i <= ch_hi ? hi : 0);
      chk($sformatf("%s_ovf_ch%0d", nm, i), int'(b0.ovf_out), 0, 0);
    end
    s0s = '0;
  endtask
  initial begin
    int c, c2;
    b0.start = 0;
    b0.abort = 0;
    b0.gate_len = '0;
    b1.start = 0;
    b1.abort = 0;
    b1.gate_len = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy0", int'(b0.busy), 0, 0);
    chk("rst_done0", int'(b0.done), 0, 0);
    chk("rst_busy1", int'(b1.busy), 0, 0);
    rd0("rst", 0, 0, 3);
    rst = 0;
    per[0] = 4;
    go0(100, c);
    q0.push_back(mk(c, 100, 4, 0, 0, 0, 65535));
    chk("busy0_armed", int'(b0.busy), 1, 1);
    idle0();
    go0(50, c);
    repeat (22) @(negedge clk);
    b0.abort = 1;
    @(negedge clk);
    b0.abort = 0;
    chk("abort_busy0", int'(b0.busy), 0, 0);
    chk("abort_done0", int'(b0.done), 0, 0);
    rd0("abort_keep", 24, 26, 0);
    repeat (60) @(negedge clk);
    per = '{2, 3, 5, 8, 0, 0, 2};
    go0(240, c);
    q0.push_back(mk(c, 240, 2, 3, 5, 8, 65535));
    idle0();
    go0(30, c);
    q0.push_back(mk(c, 30, 2, 3, 5, 8, 65535));
    repeat (5) @(negedge clk);
    go0(7, c2);
    idle0();
    go0(0, c2);
    chk("zero_len_busy0", int'(b0.busy), 0, 0);
    repeat (40) @(negedge clk);
    go0(100, c);
    repeat (30) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst_busy0", int'(b0.busy), 0, 0);
    chk("midrst_done0", int'(b0.done), 0, 0);
    rd0("midrst", 0, 0, 3);
    go0(40, c);
    q0.push_back(mk(c, 40, 2, 3, 5, 8, 65535));
    idle0();
    per = '{0, 0, 0, 0, 0, 0, 2};
    go1(1000, c);
    q1.push_back(mk(c, 1000, 0, 0, 2, 0, 255));
    idle1();
    go1(10, c);
    q1.push_back(mk(c, 10, 0, 0, 2, 0, 255));
    idle1();
    repeat (5) @(negedge clk);
    chk("q0_drained", q0.size(), 0, 0);
    chk("q1_drained", q1.size(), 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ring_freq_meter.md
# ring_freq_meter

Multi-channel ring-oscillator frequency meter. It counts rising edges on N_CH ring-oscillator outputs over a programmable gate window of reference-clock cycles, then latches one count per channel into readable result registers. It replaces the single-channel, fixed-window counting circuit in the ring-oscillator measurement path. It adds start/done handshaking, abort, saturation with an overflow flag, and a channel-select readout. Ring inputs are synchronised into the `clk` domain, so the design uses a single clock.

## Interface
- N_CH, 4 — number of ring-oscillator channels (≥1)
- CNT_W, 16 — edge-counter and result width
- GATE_W, 16 — gate-length width
- CH_W, 2 — ch_sel width, set by the integrator to max(1, ceil(log2(N_CH)))

- clk  in  1  reference clock; the only clock in the block
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a measurement
- abort  in  1  cancels a measurement in progress
- gate_len  in  GATE_W  gate window in clk cycles, sampled when start is accepted
- ring_in  in  N_CH  asynchronous ring-oscillator outputs
- ch_sel  in  CH_W  result channel to read
- busy  out  1  high in ARM, GATE and DONE
- done  out  1  one-cycle pulse; results valid and updated
- value_out  out  CNT_W  result[ch_sel]; 0 if ch_sel ≥ N_CH
- ovf_out  out  1  overflow flag of ch_sel; 0 if ch_sel ≥ N_CH

## Operation
- Each ring_in bit passes through three flops (s1→s2→s3), reset to 0. A rising edge is detected when s2 & !s3.
- FSM states: IDLE, ARM, GATE, DONE. Reset puts the FSM in IDLE.
- IDLE:
  - start=1 with gate_len≠0: latch gate_len, clear all live counters and live ovf, go to ARM.
  - start=1 with gate_len=0: ignored; stay in IDLE, no done pulse.
- ARM: exactly 3 cycles; edges are not counted. This flushes the synchronisers. Then go to GATE.
- GATE: exactly gate_len cycles.
  - Each cycle, every channel with a detected edge increments its live counter.
  - A counter at 2^CNT_W−1 holds its value and sets that channel's live ovf, which stays set until the next accepted start.
  - After the last cycle, go to DONE.
- DONE: one cycle.
  - done=1.
  - result[i]/ovf[i] hold the final live values, loaded on the clock edge that enters DONE.
  - Next cycle: IDLE.
- abort=1 in ARM or GATE: next state is IDLE. Results are not updated and there is no done pulse. abort in IDLE or DONE is ignored. If abort and the final-GATE transition coincide, abort wins.
- start while busy=1 is ignored and not queued.
- Result registers keep their values until the next completed measurement. Readout is a combinational mux on ch_sel.
- rst mid-measurement: FSM→IDLE, busy=0, done=0, live counters, results, ovf and synchronisers all cleared on the same edge.

## Timing
- Reset values: busy=0, done=0, value_out=0, ovf_out=0.
- start accepted on edge T:
  - busy=1 from cycle T+1.
  - ARM covers cycles T+1..T+3.
  - GATE covers cycles T+4..T+3+G (G = latched gate_len).
  - DONE is cycle T+4+G: done=1, value_out shows the new result.
  - busy=0 and the next start is accepted from cycle T+5+G.
- ring_in edge to detection: 2–3 clk cycles. Edges counted are those detected while in GATE.
- Countable edge rate is at most one per 2 clk cycles. Faster inputs are aliased, and this is not flagged.
- ch_sel change to value_out/ovf_out change: combinational, same cycle.

## Test plan
- Rising edge every 4 clk on ch0, ch1 held 0, gate_len=100 → done in cycle T+104; result0 ∈ {24,25,26}, result1=0, ovf=0, busy low from T+105.
- Override CNT_W=8; ch2 toggles every clk (edge every 2 clk); gate_len=1000 → result2=255, ovf_out=1 with ch_sel=2; next run with gate_len=10 → result2≈5, ovf cleared.
- Start with gate_len=50, abort in GATE cycle 20 → no done pulse, busy=0 next cycle, previous results unchanged; a fresh start then completes normally.
- Second start pulse while busy and a start with gate_len=0 in IDLE → both ignored; exactly one done for the first run, at T+4+G.
- rst asserted mid-GATE → next cycle busy=0, done=0, all value_out/ovf_out read 0 for every ch_sel; start after reset completes normally.
- Four channels with edges every 2, 3, 5 and 8 clk, gate_len=240 → results ≈120, 80, 48, 30 (±1); ch_sel=3 beyond N_CH-1 with N_CH=3 override → value_out=0.
